// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster engine: counters, grid indices, sync/enable re-aligned to an external pixel source.
// Optional checkerboard inversion is built in when VGA_CHECKER_EN is defined.

module vga_timing_pipe #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 350,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 60,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b1,
    parameter int PIX_LAT    = 1,
    parameter int CELL_SHIFT = 5,
    parameter int FRAME_W    = 8
) (
    input  logic               VGACLK,
    input  logic               RST_IN,
    input  logic [7:0]         PIXEL_DATA,
    output logic [10:0]        POS_X,
    output logic [10:0]        POS_Y,
    output logic [3:0]         GRID_X,
    output logic [3:0]         GRID_Y,
    output logic               LINE_START,
    output logic               FRAME_START,
    output logic [FRAME_W-1:0] FRAME_CNT,
    output logic               DISPLAY_EN,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic [2:0]         R,
    output logic [2:0]         G,
    output logic [1:0]         B
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Decode boundaries are kept one bit wider than the counters so an end value of 2048 still compares correctly.
    localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
    localparam logic [11:0] HS_BEGIN  = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [11:0] V_VIS_END = 12'(V_VISIBLE);
    localparam logic [11:0] VS_BEGIN  = 12'(V_VISIBLE + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);

    if (PIX_LAT < 1 || PIX_LAT > 4) begin : gBadLatency
        $error("vga_timing_pipe: PIX_LAT must be in 1..4");
    end
    if (H_SYNC == 0) begin : gBadHSync
        $error("vga_timing_pipe: H_SYNC must be non-zero");
    end
    if (V_SYNC == 0) begin : gBadVSync
        $error("vga_timing_pipe: V_SYNC must be non-zero");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : gBadTotal
        $error("vga_timing_pipe: line/frame totals must fit the 11-bit counters");
    end

    logic               run_q, run_d;
    logic [10:0]        posX_q, posX_d;
    logic [10:0]        posY_q, posY_d;
    logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;

    // run_q holds the counters at 0,0 for the first edge after reset so that edge presents the frame origin.
    always_comb begin
        run_d      = 1'b1;
        posX_d     = posX_q;
        posY_d     = posY_q;
        frameCnt_d = frameCnt_q;
        if (run_q) begin
            if (posX_q == H_LAST) begin
                posX_d = 11'd0;
                if (posY_q == V_LAST) begin
                    posY_d     = 11'd0;
                    frameCnt_d = frameCnt_q + FRAME_W'(1);
                end else begin
                    posY_d = posY_q + 11'd1;
                end
            end else begin
                posX_d = posX_q + 11'd1;
            end
        end
    end

    always_ff @(posedge VGACLK or posedge RST_IN) begin
        if (RST_IN) begin
            run_q      <= 1'b0;
            posX_q     <= 11'd0;
            posY_q     <= 11'd0;
            frameCnt_q <= '0;
        end else begin
            run_q      <= run_d;
            posX_q     <= posX_d;
            posY_q     <= posY_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    logic [11:0] x12, y12;
    logic        visRaw, hsRaw, vsRaw;

    assign x12 = {1'b0, posX_q};
    assign y12 = {1'b0, posY_q};

    // The held reset-state position is not a real sample, so every raw flag is qualified by run_q.
    assign visRaw = run_q && (x12 < H_VIS_END) && (y12 < V_VIS_END);
    assign hsRaw  = run_q && (x12 >= HS_BEGIN) && (x12 < HS_END);
    assign vsRaw  = run_q && (y12 >= VS_BEGIN) && (y12 < VS_END);

    assign POS_X       = posX_q;
    assign POS_Y       = posY_q;
    assign GRID_X      = 4'(posX_q >> CELL_SHIFT);
    assign GRID_Y      = 4'(posY_q >> CELL_SHIFT);
    assign LINE_START  = run_q && (posX_q == 11'd0);
    assign FRAME_START = run_q && (posX_q == 11'd0) && (posY_q == 11'd0);
    assign FRAME_CNT   = frameCnt_q;

    logic [PIX_LAT-1:0] visDly_q, visDly_d;
    logic [PIX_LAT-1:0] hsDly_q, hsDly_d;
    logic [PIX_LAT-1:0] vsDly_q, vsDly_d;

    // Bit 0 takes the stage-0 flag; bit PIX_LAT-1 lines up with PIXEL_DATA for the same position.
    always_comb begin
        visDly_d = PIX_LAT'({visDly_q, visRaw});
        hsDly_d  = PIX_LAT'({hsDly_q, hsRaw});
        vsDly_d  = PIX_LAT'({vsDly_q, vsRaw});
    end

    always_ff @(posedge VGACLK or posedge RST_IN) begin
        if (RST_IN) begin
            visDly_q <= '0;
            hsDly_q  <= '0;
            vsDly_q  <= '0;
        end else begin
            visDly_q <= visDly_d;
            hsDly_q  <= hsDly_d;
            vsDly_q  <= vsDly_d;
        end
    end

`ifdef VGA_CHECKER_EN
    logic               parRaw;
    logic [PIX_LAT-1:0] parDly_q, parDly_d;

    assign parRaw = run_q && (GRID_X[0] ^ GRID_Y[0]);

    always_comb begin
        parDly_d = PIX_LAT'({parDly_q, parRaw});
    end

    always_ff @(posedge VGACLK or posedge RST_IN) begin
        if (RST_IN) begin
            parDly_q <= '0;
        end else begin
            parDly_q <= parDly_d;
        end
    end
`endif

    logic [7:0] rgb_q, rgb_d;
    logic       de_q, de_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    always_comb begin
        rgb_d = 8'h00;
        de_d  = visDly_q[PIX_LAT-1];
        hs_d  = hsDly_q[PIX_LAT-1] ? H_POL : ~H_POL;
        vs_d  = vsDly_q[PIX_LAT-1] ? V_POL : ~V_POL;
        if (visDly_q[PIX_LAT-1]) begin
`ifdef VGA_CHECKER_EN
            rgb_d = parDly_q[PIX_LAT-1] ? ~PIXEL_DATA : PIXEL_DATA;
`else
            rgb_d = PIXEL_DATA;
`endif
        end
    end

    always_ff @(posedge VGACLK or posedge RST_IN) begin
        if (RST_IN) begin
            rgb_q <= 8'h00;
            de_q  <= 1'b0;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign DISPLAY_EN = de_q;
    assign HSYNC      = hs_q;
    assign VSYNC      = vs_q;
    assign R          = rgb_q[7:5];
    assign G          = rgb_q[4:2];
    assign B          = rgb_q[1:0];

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Parametrised VGA raster engine; successor to the fixed 640x350 horizontal/vertical counter pair.
- Generates pixel coordinates, grid-cell indices, sync and display-enable from one pixel clock.
- Re-aligns sync/enable with RGB data returned by an external pixel source of configurable latency.
- Sits between the clock-generator output (VGACLK) and the VGA connector; the pixel source (framebuffer/pattern) is outside this block.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSYNC pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 350, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 60, vertical back porch (lines)
- H_POL, 0, HSYNC active level (0 = active-low)
- V_POL, 1, VSYNC active level
- PIX_LAT, 1, pixel-source latency in clocks, legal 1..4
- CELL_SHIFT, 5, log2 of grid cell size in pixels
- FRAME_W, 8, frame counter width

Ports:
- VGACLK  in  1  pixel clock
- RST_IN  in  1  asynchronous reset, active-high
- PIXEL_DATA  in  8  RGB332 returned PIX_LAT clocks after POS_X/POS_Y
- POS_X  out  11  horizontal counter (0..H_TOTAL-1)
- POS_Y  out  11  vertical counter (0..V_TOTAL-1)
- GRID_X  out  4  POS_X >> CELL_SHIFT, truncated to 4 bits
- GRID_Y  out  4  POS_Y >> CELL_SHIFT, truncated to 4 bits
- LINE_START  out  1  one-clock pulse when POS_X==0
- FRAME_START  out  1  one-clock pulse when POS_X==0 and POS_Y==0
- FRAME_CNT  out  FRAME_W  completed-frame count, wraps
- DISPLAY_EN  out  1  pipeline-aligned visible flag
- HSYNC  out  1  pipeline-aligned horizontal sync
- VSYNC  out  1  pipeline-aligned vertical sync
- R  out  3  red
- G  out  3  green
- B  out  2  blue

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: visible [0, H_VISIBLE), front porch, sync, back porch. Frame order is the same.
- Reset (async, while RST_IN=1):
  - POS_X, POS_Y, FRAME_CNT = 0; LINE_START, FRAME_START, DISPLAY_EN = 0.
  - HSYNC = ~H_POL, VSYNC = ~V_POL, R/G/B = 0, all delay stages cleared.
- After RST_IN falls, the first edge presents POS_X=0, POS_Y=0, so LINE_START=FRAME_START=1 on that cycle.
- Counters (stage 0, registered):
  - POS_X increments every clock; at H_TOTAL-1 it wraps to 0.
  - POS_Y increments only on POS_X wrap; at V_TOTAL-1 it wraps to 0 together with POS_X, and FRAME_CNT increments (mod 2^FRAME_W) on the same edge.
- Stage-0 raw flags, decoded combinationally from the counters:
  - vis = POS_X<H_VISIBLE && POS_Y<V_VISIBLE
  - hs_raw active for POS_X in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC)
  - vs_raw active for POS_Y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), held for whole lines
- Alignment: vis, hs_raw, vs_raw and the grid parity bit go through a shift register of depth PIX_LAT. The output stage registers them together with RGB, so DISPLAY_EN/HSYNC/VSYNC/R/G/B all lag POS_X by exactly PIX_LAT+1 clocks.
- RGB output register:
  - If the delayed vis=1: R=PIXEL_DATA[7:5], G=[4:2], B=[1:0] (subject to the optional feature).
  - Otherwise RGB=0.
- Sync outputs drive H_POL/V_POL when the delayed raw flag is active, the complement otherwise.
- GRID_X/GRID_Y are combinational from POS_X/POS_Y (stage 0, not delayed).
- PIX_LAT outside 1..4 is a elaboration error ($error in generate).
- Any zero porch or sync width is legal except H_SYNC=0 / V_SYNC=0, which are elaboration errors.

Optional Feature:
- Macro: VGA_CHECKER_EN.
- Defined: checkerboard inversion. Delayed parity = GRID_X[0]^GRID_Y[0], sampled at stage 0 and carried through the delay line. When parity=1 and vis=1, RGB = bitwise inverse of PIXEL_DATA fields.
- Undefined: RGB passes through unmodified; parity logic is absent.

Test Plan (small timing: H 8/2/3/3 → H_TOTAL=16; V 4/1/2/1 → V_TOTAL=8; PIX_LAT=2; CELL_SHIFT=1; H_POL=0; V_POL=1):
- Reset release → POS_X runs 0..15 then 0; POS_Y steps every 16 clocks, wraps after 128 clocks; FRAME_START pulses every 128 clocks; FRAME_CNT=1 after first wrap.
- Sync alignment → HSYNC low for 3 clocks, starting 3 clocks after POS_X==10; VSYNC high for 32 clocks, starting 3 clocks after POS_Y becomes 5 with POS_X==0.
- PIXEL_DATA model returns {POS_X[2:0],POS_Y[2:0],2'b01} delayed 2 clocks → R/G/B match the sample for POS 3 clocks earlier during visible; RGB=0 and DISPLAY_EN=0 at POS_X=8..15 and POS_Y=4..7.
- VGA_CHECKER_EN defined, PIXEL_DATA=8'hA5 constant → cell (0,0) outputs R=5,G=1,B=1; cell (1,0), i.e. POS_X=2..3, outputs R=2,G=6,B=2.
- Assert RST_IN mid-line at POS_X=6, POS_Y=2 → immediately POS=0, HSYNC=1, VSYNC=0, RGB=0; the sequence restarts cleanly after release.
- FRAME_W=2, run 5 frames → FRAME_CNT sequence 1,2,3,0,1.
